// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/op request and result/flags response handshake bundle for alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with registered result/flags; define ALU_SEQ_MUL_EN for the
// iterative shift-add MUL (op 11), otherwise op 11 returns 0 like ops 12-15.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd11;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t           state;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             accept;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign accept        = bus.in_valid && bus.in_ready;

  assign sh   = bus.b[SHW-1:0];
  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  // The extra MSB of the widened difference is exactly the unsigned borrow.
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLL:  alu_res = bus.a << sh;
      OP_SRL:  alu_res = bus.a >> sh;
      OP_SRA:  alu_res = $signed(bus.a) >>> sh;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   cnt;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
`ifdef ALU_SEQ_MUL_EN
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= acc_next;
            flags_q     <= {acc_next[WIDTH-1], (acc_next == '0), 2'b00};
          end
        end
`endif
        default: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (bus.op == OP_MUL) begin
              state       <= BUSY;
              out_valid_q <= 1'b0;
              mcand       <= bus.a;
              mplier      <= bus.b;
              acc         <= '0;
              cnt         <= '0;
            end else
`endif
            begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              flags_q     <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - table-driven scoreboard bench for alu_seq (WIDTH=16), either MUL build
module tb_alu_seq;
  localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_EXTRA = 2 * W;
`else
  localparam int MUL_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int passed = 0;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] res, input logic [3:0] flg);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
  endtask

  task automatic run_vectors(input bit stall, output int cyc);
    int idx;
    vec_t e;
    idx = 0;
    cyc = 0;
    sb.delete();
    while ((idx < vecs.size() || sb.size() != 0) && cyc < 3000) begin
      if (idx < vecs.size()) drive(vecs[idx].op, vecs[idx].a, vecs[idx].b);
      else bus.in_valid = 1'b0;
      bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: got result 0x%0h expected no pending output", bus.result);
        end else begin
          e = sb.pop_front();
          check($sformatf("vec op%0d a=%h b=%h result", e.op, e.a, e.b), bus.result, e.res);
          check($sformatf("vec op%0d a=%h b=%h flags", e.op, e.a, e.b), {12'h000, bus.flags}, {12'h000, e.flg});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(vecs[idx]);
        idx++;
      end
      tick();
      cyc++;
    end
    if (cyc >= 3000) begin
      checks++;
      $display("FAIL table_timeout: got %0d outstanding expected 0", sb.size() + vecs.size() - idx);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int cyc;
    int lat;
    int low_cnt;
    int late;

    vecs.push_back(mk(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'h6));
    vecs.push_back(mk(4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'h1));
    vecs.push_back(mk(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'h9));
    vecs.push_back(mk(4'd1,  16'h0001, 16'h0002, 16'hFFFF, 4'hA));
    vecs.push_back(mk(4'd0,  16'h8000, 16'h8000, 16'h0000, 4'h7));
    vecs.push_back(mk(4'd1,  16'h0005, 16'h0005, 16'h0000, 4'h4));
    vecs.push_back(mk(4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 4'h0));
    vecs.push_back(mk(4'd3,  16'hF0F0, 16'h0F0F, 16'hFFFF, 4'h8));
    vecs.push_back(mk(4'd4,  16'hF0F0, 16'h0F0F, 16'h0000, 4'h4));
    vecs.push_back(mk(4'd5,  16'hAAAA, 16'h5555, 16'hFFFF, 4'h8));
`ifdef ALU_SEQ_MUL_EN
    vecs.push_back(mk(4'd11, 16'h00FF, 16'h0101, 16'hFFFF, 4'h8));
    vecs.push_back(mk(4'd11, 16'h1234, 16'h0003, 16'h369C, 4'h0));
`else
    vecs.push_back(mk(4'd11, 16'h0003, 16'h0005, 16'h0000, 4'h4));
    vecs.push_back(mk(4'd11, 16'h1234, 16'h0003, 16'h0000, 4'h4));
`endif
    vecs.push_back(mk(4'd6,  16'h0001, 16'h0013, 16'h0008, 4'h0));
    vecs.push_back(mk(4'd6,  16'h1234, 16'h0010, 16'h1234, 4'h0));
    vecs.push_back(mk(4'd7,  16'h8000, 16'h000F, 16'h0001, 4'h0));
    vecs.push_back(mk(4'd8,  16'h8000, 16'h0014, 16'hF800, 4'h8));
    vecs.push_back(mk(4'd8,  16'h7000, 16'h0001, 16'h3800, 4'h0));
    vecs.push_back(mk(4'd9,  16'hFFFF, 16'h0001, 16'h0001, 4'h0));
    vecs.push_back(mk(4'd9,  16'h0001, 16'hFFFF, 16'h0000, 4'h4));
    vecs.push_back(mk(4'd10, 16'hFFFF, 16'h0001, 16'h0000, 4'h4));
    vecs.push_back(mk(4'd10, 16'h0001, 16'hFFFF, 16'h0001, 4'h0));
    vecs.push_back(mk(4'd12, 16'h1234, 16'h5678, 16'h0000, 4'h4));
    vecs.push_back(mk(4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 4'h4));

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = 4'd0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", {15'h0, bus.in_ready}, 16'h1);
    check("reset out_valid", {15'h0, bus.out_valid}, 16'h0);
    check("reset result", bus.result, 16'h0000);
    check("reset flags", {12'h000, bus.flags}, 16'h0000);

    // ADD wrap with stalled consumer: latency 1, carry and zero set
    tick();
    drive(4'd0, 16'hFFFF, 16'h0001);
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("add latency out_valid", {15'h0, bus.out_valid}, 16'h1);
    check("add wrap result", bus.result, 16'h0000);
    check("add wrap flags", {12'h000, bus.flags}, 16'h0006);
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("add drained out_valid", {15'h0, bus.out_valid}, 16'h0);

    // SLT held for 3 stalled cycles, then transfer and new accept on one edge
    tick();
    drive(4'd9, 16'hFFFF, 16'h0001);
    bus.out_ready = 1'b0;
    tick();
    drive(4'd0, 16'h0002, 16'h0003);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("slt stall%0d out_valid", k), {15'h0, bus.out_valid}, 16'h1);
      check($sformatf("slt stall%0d result", k), bus.result, 16'h0001);
      check($sformatf("slt stall%0d in_ready", k), {15'h0, bus.in_ready}, 16'h0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("slt release in_ready", {15'h0, bus.in_ready}, 16'h1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("back-to-back out_valid", {15'h0, bus.out_valid}, 16'h1);
    check("back-to-back result", bus.result, 16'h0005);
    tick();
    @(negedge clk);
    check("back-to-back drained", {15'h0, bus.out_valid}, 16'h0);

`ifdef ALU_SEQ_MUL_EN
    // MUL: inputs scrambled after accept, in_ready low through BUSY
    tick();
    drive(4'd11, 16'h00FF, 16'h0101);
    bus.out_ready = 1'b0;
    tick();
    drive(4'd0, 16'hFFFF, 16'hFFFF);
    lat = 0;
    low_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      if (!bus.in_ready) low_cnt++;
      tick();
    end
    check("mul latency", 16'(lat), 16'd17);
    check("mul in_ready low cycles", 16'(low_cnt), 16'd16);
    check("mul result", bus.result, 16'hFFFF);
    check("mul flags", {12'h000, bus.flags}, 16'h0008);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("mul drained", {15'h0, bus.out_valid}, 16'h0);

    // reset 5 cycles into a MUL discards it
    tick();
    drive(4'd11, 16'h1234, 16'h5678);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mul reset out_valid", {15'h0, bus.out_valid}, 16'h0);
    check("mul reset in_ready", {15'h0, bus.in_ready}, 16'h1);
    check("mul reset result", bus.result, 16'h0000);
    late = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) late++;
    end
    check("mul reset no late result", 16'(late), 16'd0);
`else
    // op 11 without multiplier behaves as an undefined op
    tick();
    drive(4'd11, 16'h0003, 16'h0005);
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("op11 latency out_valid", {15'h0, bus.out_valid}, 16'h1);
    check("op11 result", bus.result, 16'h0000);
    check("op11 flags", {12'h000, bus.flags}, 16'h0004);
    bus.out_ready = 1'b1;
    tick();
`endif

    // reset wins over simultaneous transfer and accept while in DONE
    tick();
    drive(4'd0, 16'h0002, 16'h0003);
    bus.out_ready = 1'b0;
    tick();
    drive(4'd5, 16'h00F0, 16'h000F);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("done reset out_valid", {15'h0, bus.out_valid}, 16'h0);
    check("done reset in_ready", {15'h0, bus.in_ready}, 16'h1);
    check("done reset result", bus.result, 16'h0000);
    check("done reset flags", {12'h000, bus.flags}, 16'h0000);
    tick();

    run_vectors(1'b0, cyc);
    check("table throughput cycles", 16'(cyc), 16'(vecs.size() + 1 + MUL_EXTRA));
    tick();
    run_vectors(1'b1, cyc);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width; legal values are powers of two from 4 to 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand/op presented.
REQ-005 SHALL have port in_ready  output  1  block can accept; transfer when in_valid && in_ready at a rising edge.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B; the low $clog2(WIDTH) bits give the shift amount.
REQ-008 SHALL have port op  input  4  operation select.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid && out_ready at a rising edge.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port flags  output  4  registered {N,Z,C,V}.

Function
REQ-013 SHALL use op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed, result 1/0), 10 SLTU, 11 MUL (low WIDTH bits of product); 12-15 produce result 0.
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 SHALL make transitions: IDLE->DONE on accept of op!=11; IDLE->BUSY on accept of op 11; BUSY->DONE after WIDTH cycles; DONE->IDLE on output transfer with no new accept; DONE->DONE/BUSY on output transfer with simultaneous accept.
REQ-016 SHALL drive in_ready = (IDLE) || (DONE && out_ready); in_ready SHALL be low throughout BUSY.
REQ-017 SHALL drive out_valid high exactly in DONE.
REQ-018 SHALL capture a, b and op at accept; input changes after accept SHALL have no effect.
REQ-019 SHALL deliver single-cycle ops with latency 1: accept at edge T gives out_valid high after edge T+1. Back-to-back ops with out_ready held high SHALL sustain one result per cycle.
REQ-020 SHALL compute MUL by iterative shift-add over WIDTH BUSY cycles; accept at edge T gives out_valid after edge T+WIDTH+1.
REQ-021 SHALL hold result and flags stable while out_valid && !out_ready.
REQ-022 SHALL set flags as follows: Z = (result==0); N = result[WIDTH-1]; C = carry-out for ADD, borrow (a<b unsigned) for SUB, else 0; V = signed overflow for ADD/SUB, else 0.
REQ-023 SHALL perform all arithmetic modulo 2^WIDTH; the shift amount SHALL wrap modulo WIDTH; SRA SHALL replicate the MSB.
REQ-024 SHALL reset the BUSY iteration counter on every MUL accept; the counter SHALL never wrap into a stale state.

Reset
REQ-025 SHALL, when rst is high at an edge, force IDLE with in_ready=1, out_valid=0, result=0, flags=0, regardless of state.
REQ-026 SHALL give rst priority over a simultaneous accept or output transfer; a MUL in progress SHALL be discarded with no output.

Configuration
REQ-027 SHALL, when macro ALU_SEQ_MUL_EN is defined, implement MUL as in REQ-020.
REQ-028 SHALL, when ALU_SEQ_MUL_EN is undefined, omit the BUSY state and multiplier datapath; op 11 SHALL behave as ops 12-15 (result 0, Z=1, latency 1).

Verification (WIDTH=16)
REQ-029 SHALL cover: ADD a=0xFFFF b=0x0001 -> result 0x0000, flags N0 Z1 C1 V0, out_valid 1 cycle after accept.
REQ-030 SHALL cover: SUB a=0x8000 b=0x0001 -> result 0x7FFF, N0 Z0 C0 V1.
REQ-031 SHALL cover, with the macro defined: MUL a=0x00FF b=0x0101 -> result 0xFFFF, out_valid 17 cycles after accept, in_ready low for 16 cycles.
REQ-032 SHALL cover: SLT a=0xFFFF b=0x0001, out_ready low 3 cycles -> result 0x0001 stable; raising out_ready with in_valid high gives a transfer and a new accept on the same edge.
REQ-033 SHALL cover: rst asserted 5 cycles into a MUL -> next cycle out_valid 0, in_ready 1, result 0x0000, and no late result appears.
REQ-034 SHALL cover, with the macro undefined: op 11 a=0x0003 b=0x0005 -> result 0x0000, Z1, latency 1.
